alu_serial_ctrl: RTL and testbench

- Bit-serial sequencer for the team's one-bit ALU slice, which sits directly downstream of this block.
- Accepts a full-width operation, then drives operand bits and control into one slice, LSB first, one bit per cycle.
- Consumes the slice's result, carry and equal-chain outputs, and assembles the full-width result plus zero, carry and overflow flags.
- Used in the area-reduced CPU variant in place of the WIDTH-slice ripple ALU.

---
 rtl/alu_serial_ctrl.sv | 156 +++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// Bit-serial sequencer for the one-bit ALU slice: streams operands LSB first,
// then (for COMPARE) runs a second pass that places the compare outcome in bit 0.
module alu_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [2:0]       bonus_op_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             cout_o,
  output logic             overflow_o,
  output logic             sl_src1_o,
  output logic             sl_src2_o,
  output logic             sl_less_o,
  output logic             sl_equal_o,
  output logic             sl_in_equal_o,
  output logic             sl_a_inv_o,
  output logic             sl_b_inv_o,
  output logic             sl_cin_o,
  output logic [1:0]       sl_op_o,
  output logic [2:0]       sl_bonus_o,
  input  logic             sl_result_i,
  input  logic             sl_cout_i,
  input  logic             sl_beq_i
);

  typedef enum logic [1:0] {IDLE, RUN, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res, res_next;
  logic [3:0]       ctrl_q;
  logic [2:0]       bonus_q;
  logic [CNT_W-1:0] idx;
  logic             carry, eq_chain, sign;
  logic             last, is_cmp;

  assign last   = (idx == CNT_W'(WIDTH - 1));
  assign is_cmp = (ctrl_q[1:0] == 2'd3);
  assign busy_o = (state != IDLE);
  assign done_o = (state == DONE);

  always_comb begin
    res_next      = res;
    res_next[idx] = sl_result_i;
  end

  // Slice drive is a pure function of registered state, so it is stable for the whole cycle.
  always_comb begin
    sl_src1_o     = 1'b0;
    sl_src2_o     = 1'b0;
    sl_less_o     = 1'b0;
    sl_equal_o    = 1'b0;
    sl_in_equal_o = 1'b0;
    sl_a_inv_o    = 1'b0;
    sl_b_inv_o    = 1'b0;
    sl_cin_o      = 1'b0;
    sl_op_o       = 2'd0;
    sl_bonus_o    = 3'd0;
    if (state == RUN || state == CMP) begin
      sl_src1_o     = a_q[idx];
      sl_src2_o     = b_q[idx];
      sl_a_inv_o    = ctrl_q[3];
      sl_b_inv_o    = ctrl_q[2];
      sl_cin_o      = carry;
      sl_in_equal_o = eq_chain;
    end
    if (state == RUN) begin
      sl_op_o = is_cmp ? 2'd2 : ctrl_q[1:0];
    end
    if (state == CMP) begin
      sl_op_o = 2'd3;
      // Only bit 0 carries the compare outcome; higher bits use "zero" select.
      if (idx == '0) begin
        sl_bonus_o = bonus_q;
        sl_less_o  = sign ^ overflow_o;
        sl_equal_o = eq_chain;
      end else begin
        sl_bonus_o = 3'd7;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      ctrl_q     <= '0;
      bonus_q    <= '0;
      idx        <= '0;
      carry      <= 1'b0;
      eq_chain   <= 1'b0;
      sign       <= 1'b0;
      res        <= '0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      cout_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            a_q      <= src1_i;
            b_q      <= src2_i;
            ctrl_q   <= alu_ctrl_i;
            bonus_q  <= bonus_op_i;
            idx      <= '0;
            carry    <= alu_ctrl_i[2];
            eq_chain <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          carry    <= sl_cout_i;
          eq_chain <= sl_beq_i;
          idx      <= idx + 1'b1;
          if (!is_cmp) res <= res_next;
          if (last) begin
            cout_o     <= sl_cout_i;
            overflow_o <= carry ^ sl_cout_i;
            sign       <= sl_result_i;
            idx        <= '0;
            if (is_cmp) begin
              state <= CMP;
            end else begin
              state    <= DONE;
              result_o <= res_next;
              zero_o   <= (res_next == '0);
            end
          end
        end
        CMP: begin
          res <= res_next;
          idx <= idx + 1'b1;
          if (last) begin
            idx      <= '0;
            state    <= DONE;
            result_o <= res_next;
            zero_o   <= (res_next == '0);
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed bench for alu_serial_ctrl; includes a behavioural model of the
// downstream one-bit ALU slice so the sequencer sees realistic feedback.
module tb_alu_serial_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [31:0] src1_i = '0, src2_i = '0;
  logic [3:0]  alu_ctrl_i = '0;
  logic [2:0]  bonus_op_i = '0;
  logic        busy_o, done_o, zero_o, cout_o, overflow_o;
  logic [31:0] result_o;
  logic        sl_src1_o, sl_src2_o, sl_less_o, sl_equal_o, sl_in_equal_o;
  logic        sl_a_inv_o, sl_b_inv_o, sl_cin_o;
  logic [1:0]  sl_op_o;
  logic [2:0]  sl_bonus_o;
  logic        sl_result_i, sl_cout_i, sl_beq_i;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk_i = ~clk_i;

  alu_serial_ctrl #(.WIDTH(32), .CNT_W(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .src1_i(src1_i), .src2_i(src2_i), .alu_ctrl_i(alu_ctrl_i), .bonus_op_i(bonus_op_i),
    .busy_o(busy_o), .done_o(done_o), .result_o(result_o), .zero_o(zero_o),
    .cout_o(cout_o), .overflow_o(overflow_o),
    .sl_src1_o(sl_src1_o), .sl_src2_o(sl_src2_o), .sl_less_o(sl_less_o),
    .sl_equal_o(sl_equal_o), .sl_in_equal_o(sl_in_equal_o),
    .sl_a_inv_o(sl_a_inv_o), .sl_b_inv_o(sl_b_inv_o), .sl_cin_o(sl_cin_o),
    .sl_op_o(sl_op_o), .sl_bonus_o(sl_bonus_o),
    .sl_result_i(sl_result_i), .sl_cout_i(sl_cout_i), .sl_beq_i(sl_beq_i)
  );

  // One-bit ALU slice: inverted operands feed AND/OR/full-adder; op 3 selects a compare outcome.
  logic sa, sb, ssum;
  always_comb begin
    sa          = sl_src1_o ^ sl_a_inv_o;
    sb          = sl_src2_o ^ sl_b_inv_o;
    ssum        = sa ^ sb ^ sl_cin_o;
    sl_cout_i   = (sa & sb) | (sl_cin_o & (sa ^ sb));
    sl_beq_i    = sl_in_equal_o & (sl_src1_o == sl_src2_o);
    sl_result_i = 1'b0;
    case (sl_op_o)
      2'd0: sl_result_i = sa & sb;
      2'd1: sl_result_i = sa | sb;
      2'd2: sl_result_i = ssum;
      default: begin
        case (sl_bonus_o)
          3'd0: sl_result_i = sl_less_o;
          3'd1: sl_result_i = !sl_less_o && !sl_equal_o;
          3'd2: sl_result_i = sl_less_o || sl_equal_o;
          3'd3: sl_result_i = !sl_less_o;
          3'd4: sl_result_i = !sl_equal_o;
          3'd6: sl_result_i = sl_equal_o;
          default: sl_result_i = 1'b0;
        endcase
      end
    endcase
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Presents an operation for one cycle; returns at the negedge of the first RUN cycle.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] ctrl, input logic [2:0] bonus);
    @(negedge clk_i);
    src1_i = a; src2_i = b; alu_ctrl_i = ctrl; bonus_op_i = bonus; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    src1_i = ~a; src2_i = ~b; bonus_op_i = ~bonus;
  endtask

  task automatic waitDone(input int start_cnt, input int exp_lat, input string tag);
    int cnt = start_cnt;
    while (!done_o && cnt < 200) begin
      @(negedge clk_i);
      cnt++;
    end
    checkOutput({tag, "_latency"}, 32'(cnt), 32'(exp_lat));
  endtask

  function automatic logic [12:0] sl_bus();
    return {sl_src1_o, sl_src2_o, sl_less_o, sl_equal_o, sl_in_equal_o,
            sl_a_inv_o, sl_b_inv_o, sl_cin_o, sl_op_o, sl_bonus_o};
  endfunction

  initial begin
    int pulses;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_done", 32'(done_o), 0);
    checkOutput("rst_result", result_o, 0);
    checkOutput("rst_zero", 32'(zero_o), 1);
    checkOutput("rst_slice_bus", 32'(sl_bus()), 0);

    // ADD with signed overflow; also checks first-bit slice drive
    applyStimulus(32'h7FFFFFFF, 32'h00000001, 4'b0010, 3'd0);
    checkOutput("add_busy", 32'(busy_o), 1);
    checkOutput("add_k0_bus", 32'(sl_bus()), 32'(13'b1_1_0_0_1_0_0_0_10_000));
    waitDone(1, 33, "add");
    checkOutput("add_result", result_o, 32'h80000000);
    checkOutput("add_overflow", 32'(overflow_o), 1);
    checkOutput("add_cout", 32'(cout_o), 0);
    checkOutput("add_zero", 32'(zero_o), 0);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    checkOutput("done_start_ignored_busy", 32'(busy_o), 0);
    checkOutput("add_result_hold", result_o, 32'h80000000);
    checkOutput("add_done_pulse_end", 32'(done_o), 0);

    // SUB to zero
    applyStimulus(32'h00000005, 32'h00000005, 4'b0110, 3'd0);
    checkOutput("sub_k0_cin", 32'(sl_cin_o), 1);
    waitDone(1, 33, "sub");
    checkOutput("sub_result", result_o, 32'h0);
    checkOutput("sub_zero", 32'(zero_o), 1);
    checkOutput("sub_cout", 32'(cout_o), 1);
    checkOutput("sub_overflow", 32'(overflow_o), 0);

    // SLT -1 < 1, with slice drive checked in RUN and at the first CMP bit
    applyStimulus(32'hFFFFFFFF, 32'h00000001, 4'b0111, 3'd0);
    checkOutput("slt_run_op", 32'(sl_op_o), 2);
    checkOutput("slt_run_cin", 32'(sl_cin_o), 1);
    repeat (32) @(negedge clk_i);
    checkOutput("slt_cmp0_op", 32'(sl_op_o), 3);
    checkOutput("slt_cmp0_bonus", 32'(sl_bonus_o), 0);
    checkOutput("slt_cmp0_less", 32'(sl_less_o), 1);
    @(negedge clk_i);
    checkOutput("slt_cmp1_bonus", 32'(sl_bonus_o), 7);
    waitDone(34, 65, "slt");
    checkOutput("slt_result", result_o, 32'h00000001);

    applyStimulus(32'hFFFFFFFF, 32'h00000001, 4'b0111, 3'd3);
    waitDone(1, 65, "sge");
    checkOutput("sge_result", result_o, 32'h00000000);
    checkOutput("sge_zero", 32'(zero_o), 1);

    applyStimulus(32'h80000000, 32'h00000001, 4'b0111, 3'd0);
    waitDone(1, 65, "slt_ovf");
    checkOutput("slt_ovf_result", result_o, 32'h00000001);

    applyStimulus(32'h00001234, 32'h00001234, 4'b0111, 3'd6);
    waitDone(1, 65, "seq");
    checkOutput("seq_result", result_o, 32'h00000001);

    applyStimulus(32'h00001234, 32'h00001235, 4'b0111, 3'd1);
    waitDone(1, 65, "sgt");
    checkOutput("sgt_result", result_o, 32'h00000000);

    // NOR (inverted AND) with a stray start pulse mid-run
    applyStimulus(32'hF0F0F0F0, 32'h0F0F0F00, 4'b1100, 3'd0);
    repeat (9) @(negedge clk_i);
    src1_i = 32'h0; src2_i = 32'h0; alu_ctrl_i = 4'b0010; start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    waitDone(11, 33, "nor");
    checkOutput("nor_result", result_o, 32'h0000000F);

    // OR
    applyStimulus(32'h00F000A0, 32'h0F00000B, 4'b0001, 3'd0);
    waitDone(1, 33, "or");
    checkOutput("or_result", result_o, 32'h0FF000AB);

    // Reset in the middle of an ADD
    applyStimulus(32'h11111111, 32'h22222222, 4'b0010, 3'd0);
    repeat (9) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    checkOutput("midrst_busy", 32'(busy_o), 0);
    checkOutput("midrst_result", result_o, 32'h0);
    checkOutput("midrst_zero", 32'(zero_o), 1);
    pulses = 0;
    repeat (40) begin
      @(negedge clk_i);
      if (done_o) pulses++;
    end
    checkOutput("midrst_no_done", 32'(pulses), 0);
    applyStimulus(32'h00000003, 32'h00000004, 4'b0010, 3'd0);
    waitDone(1, 33, "after_rst");
    checkOutput("after_rst_result", result_o, 32'h00000007);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
